// File: rtl/mux21_arb_pkg.sv
// Shared state encoding and source tags for the round-robin 2:1 mux arbiter.
package mux21_arb_pkg;

   // One-hot grant states: bit 0 is the A grant, bit 1 is the B grant.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GNT_A = 2'b01,
      ST_GNT_B = 2'b10
   } state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux21_data.sv
// Combinational DATA_W-wide 2:1 data mux shared by requesters A and B.
module mux21_data
   import mux21_arb_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic              sel,
   output logic [DATA_W-1:0] data_y
);

   assign data_y = (sel == SRC_B) ? data_b : data_a;

endmodule

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter owning one 2:1 mux, with a registered valid/ready output stage
// and a per-grant transfer bound while the other side is waiting.
module mux21_arbiter
   import mux21_arb_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_a,
   input  logic [DATA_W-1:0] data_a,
   input  logic              req_b,
   input  logic [DATA_W-1:0] data_b,
   input  logic              out_ready,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src
);

   localparam int              HC_W      = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_q, last_d;
   logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_src_q, out_src_d;
   logic [DATA_W-1:0] mux_data_s;
   logic              req_own_s, req_oth_s, stall_s, xfer_s;

   mux21_data #(.DATA_W(DATA_W)) u_data (
      .data_a (data_a),
      .data_b (data_b),
      .sel    (sel_q),
      .data_y (mux_data_s)
   );

   // Owner-relative request view plus the stall and transfer qualifiers.
   always_comb begin
      req_own_s = 1'b0;
      req_oth_s = 1'b0;
      case (state_q)
         ST_GNT_A: begin
            req_own_s = req_a;
            req_oth_s = req_b;
         end
         ST_GNT_B: begin
            req_own_s = req_b;
            req_oth_s = req_a;
         end
         default: begin
            req_own_s = 1'b0;
            req_oth_s = 1'b0;
         end
      endcase
      stall_s = out_valid_q & ~out_ready;
      xfer_s  = req_own_s & ~stall_s;
   end

   // Grant FSM, round-robin memory and per-grant hold counter.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_a && req_b) begin
               if (last_q == SRC_A) begin
                  state_d = ST_GNT_B;
                  sel_d   = SRC_B;
               end else begin
                  state_d = ST_GNT_A;
                  sel_d   = SRC_A;
               end
            end else if (req_a) begin
               state_d = ST_GNT_A;
               sel_d   = SRC_A;
            end else if (req_b) begin
               state_d = ST_GNT_B;
               sel_d   = SRC_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GNT_A, ST_GNT_B: begin
            if (stall_s) begin
               state_d = state_q;
            end else if ((xfer_s && (hold_cnt_q == HOLD_LAST) && req_oth_s) ||
                         (!req_own_s && req_oth_s)) begin
               state_d    = (state_q == ST_GNT_A) ? ST_GNT_B : ST_GNT_A;
               sel_d      = (state_q == ST_GNT_A) ? SRC_B : SRC_A;
               last_d     = (state_q == ST_GNT_A) ? SRC_A : SRC_B;
               hold_cnt_d = '0;
            end else if (!req_own_s) begin
               state_d    = ST_IDLE;
               last_d     = (state_q == ST_GNT_A) ? SRC_A : SRC_B;
               hold_cnt_d = '0;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
               // Uncontended owner: counter parks at its last value.
               hold_cnt_d = hold_cnt_q;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase
   end

   // Output stage: capture on transfer, drain on accept, hold while stalled.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer_s) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data_s;
         out_src_d   = sel_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= SRC_A;
         last_q      <= SRC_B;
         hold_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= SRC_A;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   // Grants come straight off the one-hot state flops.
   assign gnt_a     = state_q[0];
   assign gnt_b     = state_q[1];
   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule
